// File: rtl/sram_ctrl.sv
// Cache-side memory port to external asynchronous 32-bit SRAM, one word per access.
// Define SRAM_CTRL_RANGE_CHK_EN to drop accesses whose mem_adbus[31:20] differs from BASE.
module sram_ctrl #(
    parameter int unsigned AW          = 18,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [11:0] BASE        = 12'h000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          read_mem,
    input  logic          write_mem,
    output logic          grant_mem,
    output logic          ready_mem,
    inout  wire  [31:0]   mem_databus,
    input  logic [31:0]   mem_adbus,
    output logic [AW-1:0] sram_addr,
    inout  wire  [31:0]   sram_dq,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic [3:0]    sram_be_n,
    output logic          err
);

    localparam logic [31:0] BadData = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {StIdle, StGrant, StAccess, StHold, StDone} state_e;

    state_e      state_q;
    logic        is_wr_q;
    logic [3:0]  wait_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        dq_oe_q;
    logic        bus_oe_q;
    logic        in_range;

`ifdef SRAM_CTRL_RANGE_CHK_EN
    assign in_range = (mem_adbus[31:20] == BASE);
`else
    assign in_range = 1'b1;
`endif

    logic unused_adbus;
    assign unused_adbus = ^{mem_adbus[1:0], mem_adbus[31:AW+2]};

    assign sram_dq     = dq_oe_q  ? wdata_q : 32'hz;
    assign mem_databus = bus_oe_q ? rdata_q : 32'hz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            is_wr_q   <= 1'b0;
            wait_q    <= 4'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            dq_oe_q   <= 1'b0;
            bus_oe_q  <= 1'b0;
            grant_mem <= 1'b0;
            ready_mem <= 1'b0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= 4'hF;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (read_mem || write_mem) begin
                        is_wr_q   <= write_mem;
                        grant_mem <= 1'b1;
                        state_q   <= StGrant;
                    end
                end
                StGrant: begin
                    sram_addr <= mem_adbus[AW+1:2];
                    wait_q    <= 4'(WAIT_CYCLES - 1);
                    if (is_wr_q) begin
                        wdata_q <= mem_databus;
                    end
                    if (in_range) begin
                        sram_ce_n <= 1'b0;
                        sram_be_n <= 4'h0;
                        sram_oe_n <= is_wr_q;
                        sram_we_n <= !is_wr_q;
                        dq_oe_q   <= is_wr_q;
                        state_q   <= StAccess;
                    end else begin
                        // Out-of-range: no SRAM cycle, reads see a poison word.
                        rdata_q   <= BadData;
                        err       <= 1'b1;
                        ready_mem <= 1'b1;
                        bus_oe_q  <= !is_wr_q;
                        state_q   <= StDone;
                    end
                end
                StAccess: begin
                    if (wait_q == 4'd0) begin
                        if (!is_wr_q) begin
                            rdata_q <= sram_dq;
                        end
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        state_q   <= StHold;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                StHold: begin
                    // Write data stays on sram_dq through this cycle for hold time.
                    sram_ce_n <= 1'b1;
                    sram_be_n <= 4'hF;
                    dq_oe_q   <= 1'b0;
                    ready_mem <= 1'b1;
                    bus_oe_q  <= !is_wr_q;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (!read_mem && !write_mem) begin
                        ready_mem <= 1'b0;
                        grant_mem <= 1'b0;
                        bus_oe_q  <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: behavioural async SRAM plus a read-data scoreboard.
module tb_sram_ctrl;

    localparam int unsigned W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read_mem = 1'b0;
    logic        write_mem = 1'b0;
    logic [31:0] adbus = 32'd0;
    logic [31:0] tb_wdata = 32'd0;
    logic        tb_drv = 1'b0;
    logic        grant_mem, ready_mem, sram_ce_n, sram_oe_n, sram_we_n, err;
    logic [3:0]  sram_be_n;
    logic [17:0] sram_addr;
    wire  [31:0] mem_databus;
    wire  [31:0] sram_dq;

    logic [31:0] sram_mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_a = 8'd0;
    logic [31:0] pre_d = 32'd0;

    logic [31:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.AW(18), .WAIT_CYCLES(W), .BASE(12'h000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_mem   (read_mem),
        .write_mem  (write_mem),
        .grant_mem  (grant_mem),
        .ready_mem  (ready_mem),
        .mem_databus(mem_databus),
        .mem_adbus  (adbus),
        .sram_addr  (sram_addr),
        .sram_dq    (sram_dq),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_be_n  (sram_be_n),
        .err        (err)
    );

    assign mem_databus = tb_drv ? tb_wdata : 32'hz;
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr[7:0]] : 32'hz;

    always @(posedge clk) begin
        if (pre_we) sram_mem[pre_a] <= pre_d;
        else if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        @(posedge clk); #1 pre_we = 1'b0;
    endtask

    // One cache transaction; lat is the edge index (E0 = 0) after which ready_mem rises.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] adr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input int lat, input int exp_oe,
                          input int exp_we, input int exp_err, input bit drop);
        int k, oe_cnt, we_cnt, hold_cnt, err_cnt;
        logic got, addr_ok, hold_ok;
        k = 0; oe_cnt = 0; we_cnt = 0; hold_cnt = 0; err_cnt = 0;
        got = 1'b0; addr_ok = 1'b1; hold_ok = 1'b1;
        @(negedge clk);
        read_mem = rd; write_mem = wr; adbus = adr; tb_wdata = wd; tb_drv = wr;
        if (rd && !wr) sb.push_back(exp_rd);
        while (!got && k < 40) begin
            @(posedge clk); @(negedge clk); k++;
            if (k == 1) begin
                check({tag, " grant@E0"}, grant_mem, 1'b1);
                check({tag, " ce_n@E0"}, sram_ce_n, 1'b1);
            end
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) we_cnt++;
            if (err) err_cnt++;
            if (!sram_ce_n && (sram_addr !== adr[19:2] || sram_be_n !== 4'h0)) addr_ok = 1'b0;
            if (!sram_ce_n && sram_oe_n && sram_we_n) begin
                hold_cnt++;
                if (wr && sram_dq !== wd) hold_ok = 1'b0;
            end
            if (drop && k == 2) begin
                read_mem = 1'b0; write_mem = 1'b0; tb_drv = 1'b0;
            end
            got = ready_mem;
        end
        check({tag, " edges"}, k, lat + 1);
        check({tag, " oe_cycles"}, oe_cnt, exp_oe);
        check({tag, " we_cycles"}, we_cnt, exp_we);
        check({tag, " addr/be"}, addr_ok, 1'b1);
        check({tag, " hold_cycles"}, hold_cnt, (exp_oe + exp_we > 0) ? 1 : 0);
        check({tag, " hold_data"}, hold_ok, 1'b1);
        if (got && rd && !wr && sb.size() > 0) check({tag, " rdata"}, mem_databus, sb.pop_front());
        @(posedge clk); @(negedge clk);
        if (err) err_cnt++;
        if (!drop) begin
            check({tag, " ready_persist"}, ready_mem, 1'b1);
            if (rd && !wr) check({tag, " rdata_persist"}, mem_databus, exp_rd);
            read_mem = 1'b0; write_mem = 1'b0; tb_drv = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        check({tag, " ready_drop"}, ready_mem, 1'b0);
        check({tag, " grant_drop"}, grant_mem, 1'b0);
        check({tag, " err_pulses"}, err_cnt, exp_err);
    endtask

    initial begin
        preload(8'h10, 32'hCAFE_0001);
        preload(8'h13, 32'h0BAD_F00D);
        @(negedge clk);
        check("rst grant", grant_mem, 1'b0);
        check("rst ready", ready_mem, 1'b0);
        check("rst strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst be_n", sram_be_n, 4'hF);
        check("rst addr", sram_addr, 18'd0);
        check("rst err", err, 1'b0);
        rst_n = 1'b1;

        access("rd40", 1, 0, 32'h0000_0040, 32'd0, 32'hCAFE_0001, W + 2, W, 0, 0, 0);
        access("wr44", 0, 1, 32'h0000_0044, 32'h1234_5678, 32'd0, W + 2, 0, W, 0, 0);
        access("rd44", 1, 0, 32'h0000_0044, 32'd0, 32'h1234_5678, W + 2, W, 0, 0, 0);
        access("both48", 1, 1, 32'h0000_0048, 32'hAABB_CCDD, 32'd0, W + 2, 0, W, 0, 0);
        access("rd48", 1, 0, 32'h0000_0048, 32'd0, 32'hAABB_CCDD, W + 2, W, 0, 0, 0);
        access("droprd", 1, 0, 32'h0000_0040, 32'd0, 32'hCAFE_0001, W + 2, W, 0, 0, 1);
        access("dropwr", 0, 1, 32'h0000_0050, 32'h0000_0077, 32'd0, W + 2, 0, W, 0, 1);
        access("rd50", 1, 0, 32'h0000_0050, 32'd0, 32'h0000_0077, W + 2, W, 0, 0, 0);

        // Reset during the first ACCESS cycle of a write.
        @(negedge clk);
        write_mem = 1'b1; adbus = 32'h0000_004C; tb_wdata = 32'h55AA_55AA; tb_drv = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check("mid we_n", sram_we_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("mid rst be_n", sram_be_n, 4'hF);
        check("mid rst grant", grant_mem, 1'b0);
        check("mid rst addr", sram_addr, 18'd0);
        write_mem = 1'b0; tb_drv = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post rst idle", {grant_mem, ready_mem, sram_ce_n}, 3'b001);
        access("rd4c", 1, 0, 32'h0000_004C, 32'd0, 32'h0BAD_F00D, W + 2, W, 0, 0, 0);

`ifdef SRAM_CTRL_RANGE_CHK_EN
        access("oor_rd", 1, 0, 32'h0010_0000, 32'd0, 32'hDEAD_BEEF, 1, 0, 0, 1, 0);
        access("oor_wr", 0, 1, 32'h0010_0040, 32'h9999_9999, 32'd0, 1, 0, 0, 1, 0);
        access("rd40b", 1, 0, 32'h0000_0040, 32'd0, 32'hCAFE_0001, W + 2, W, 0, 0, 0);
`else
        access("alias", 1, 0, 32'h0010_0040, 32'd0, 32'hCAFE_0001, W + 2, W, 0, 0, 0);
`endif
        check("sb empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
